// File: rtl/score_keeper_pkg.sv
// ---------------------------------------------------------------------------
// score_keeper_pkg
//   Shared definitions for the catch-game score keeper:
//     - game state encoding (IDLE / PLAY / OVER)
//     - winner codes driven on the winner output
//     - 2-digit BCD helpers used by both the per-player counter and the
//       win-check logic, so both agree on what "the next score" is.
// ---------------------------------------------------------------------------
package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // winner = {P2 reached, P1 reached}
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Increment a packed {tens, ones} BCD pair. Ones roll 9 -> 0 with a carry
    // into tens; tens roll 9 -> 0 so the result never holds a code above 9.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // Convert a binary value 0..99 to packed {tens, ones} BCD.
    function automatic logic [7:0] to_bcd2(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((v / 10) % 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/score_keeper_bcd2_counter.sv
// ---------------------------------------------------------------------------
// bcd2_counter
//   Two-digit BCD up-counter holding one player's score.
//   Ports:
//     clk   in   1  rising-edge clock
//     rst   in   1  synchronous active-high reset, clears the count
//     clr   in   1  synchronous clear, wins over inc
//     inc   in   1  add one to the count this cycle
//     tens  out  4  tens digit (BCD)
//     ones  out  4  ones digit (BCD)
// ---------------------------------------------------------------------------
module bcd2_counter
    import score_keeper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            {tens, ones} <= bcd2_inc({tens, ones});
        end
    end

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//   Score and game-state keeper for the 2-player catch game. Feeds the
//   4-digit seven-segment display stage: D (leftmost) .. A (rightmost).
//   Parameters:
//     WIN_SCORE       decimal score that ends the game, 1..99
//     LOCKOUT_CYCLES  cycles a player's point input is ignored after an
//                     accepted point, >= 1
//   Ports:
//     clk        in   1  rising-edge clock
//     rst        in   1  synchronous active-high reset
//     p1_point   in   1  player-1 point request (level, acts on rising edge)
//     p2_point   in   1  player-2 point request (level, acts on rising edge)
//     new_game   in   1  clears scores and starts play (level)
//     D, C       out  4  player-1 tens, ones (BCD)
//     B, A       out  4  player-2 tens, ones (BCD)
//     playing    out  1  high while in PLAY
//     game_over  out  1  high while in OVER
//     winner     out  2  {P2 reached, P1 reached} in OVER, 00 otherwise
// ---------------------------------------------------------------------------
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int WIN_SCORE      = 15,
    parameter int LOCKOUT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_point,
    input  logic       p2_point,
    input  logic       new_game,
    output logic [3:0] D,
    output logic [3:0] C,
    output logic [3:0] B,
    output logic [3:0] A,
    output logic       playing,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int         LOCK_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [7:0] WIN_BCD  = to_bcd2(WIN_SCORE);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic              playing_d;
    logic              game_over_d;
    logic [1:0]        winner_d;

    logic              p1_q;
    logic              p2_q;
    logic              p1_ev;
    logic              p2_ev;
    logic [LOCK_W-1:0] p1_lock;
    logic [LOCK_W-1:0] p2_lock;
    logic              p1_accept;
    logic              p2_accept;
    logic              p1_reach;
    logic              p2_reach;

    // ---------------------------------------------------------------
    // Rising-edge detection: a held level yields exactly one event.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_q <= 1'b0;
            p2_q <= 1'b0;
        end else begin
            p1_q <= p1_point;
            p2_q <= p2_point;
        end
    end

    assign p1_ev = p1_point & ~p1_q;
    assign p2_ev = p2_point & ~p2_q;

    // A point only counts in PLAY, with no new_game this cycle and the
    // player's lockout window expired. new_game outranks any point.
    assign p1_accept = (state == ST_PLAY) && !new_game && p1_ev && (p1_lock == '0);
    assign p2_accept = (state == ST_PLAY) && !new_game && p2_ev && (p2_lock == '0);

    // ---------------------------------------------------------------
    // Per-player lockout: reload on accept, otherwise count down to 0.
    // Dropped events never reload, so bounce cannot extend the window.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_lock <= '0;
        end else if (p1_accept) begin
            p1_lock <= LOCK_LOAD;
        end else if (p1_lock != '0) begin
            p1_lock <= p1_lock - LOCK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p2_lock <= '0;
        end else if (p2_accept) begin
            p2_lock <= LOCK_LOAD;
        end else if (p2_lock != '0) begin
            p2_lock <= p2_lock - LOCK_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Score counters. new_game clears in every state.
    // ---------------------------------------------------------------
    bcd2_counter u_p1_score (
        .clk  (clk),
        .rst  (rst),
        .clr  (new_game),
        .inc  (p1_accept),
        .tens (D),
        .ones (C)
    );

    bcd2_counter u_p2_score (
        .clk  (clk),
        .rst  (rst),
        .clr  (new_game),
        .inc  (p2_accept),
        .tens (B),
        .ones (A)
    );

    // Win check looks at the score the counter is about to take, so the
    // state moves to OVER on the same edge the winning point lands. Scores
    // only ever grow by one from below WIN_SCORE, so equality suffices.
    assign p1_reach = p1_accept && (bcd2_inc({D, C}) == WIN_BCD);
    assign p2_reach = p2_accept && (bcd2_inc({B, A}) == WIN_BCD);

    // ---------------------------------------------------------------
    // FSM: state register (outputs registered alongside the state).
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            playing   <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            state     <= next_state;
            playing   <= playing_d;
            game_over <= game_over_d;
            winner    <= winner_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic.
    // ---------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (new_game) next_state = ST_PLAY;
            end
            ST_PLAY: begin
                if (new_game)                 next_state = ST_PLAY;
                else if (p1_reach || p2_reach) next_state = ST_OVER;
            end
            ST_OVER: begin
                if (new_game) next_state = ST_PLAY;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: output logic, computed from the upcoming state so the
    // registered outputs line up with the state they describe.
    // ---------------------------------------------------------------
    always_comb begin
        playing_d   = (next_state == ST_PLAY);
        game_over_d = (next_state == ST_OVER);
        winner_d    = WIN_NONE;
        if (next_state == ST_OVER) begin
            // Entering OVER latches who got there; staying in OVER holds it.
            if (state == ST_PLAY) winner_d = {p2_reach, p1_reach};
            else                  winner_d = winner;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
//   Directed scenarios followed by a randomized run, each cycle compared
//   against a behavioural model working on integer scores and accept times.
// ---------------------------------------------------------------------------
module tb_score_keeper;

    localparam int WIN  = 15;
    localparam int LOCK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] D;
    logic [3:0] C;
    logic [3:0] B;
    logic [3:0] A;
    logic       playing;
    logic       game_over;
    logic [1:0] winner;

    int n_checks = 0;
    int n_fail   = 0;

    score_keeper #(
        .WIN_SCORE      (WIN),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p1_point  (p1_point),
        .p2_point  (p2_point),
        .new_game  (new_game),
        .D         (D),
        .C         (C),
        .B         (B),
        .A         (A),
        .playing   (playing),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=play 2=over, scores as integers,
    // lockout as "cycles since last accepted point".
    int m_mode  = 0;
    int m_s1    = 0;
    int m_s2    = 0;
    int m_win   = 0;
    int m_cyc   = 0;
    int m_last1 = -1000;
    int m_last2 = -1000;
    bit m_p1q   = 1'b0;
    bit m_p2q   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit p1, input bit p2, input bit ng, input bit r);
        bit ok1;
        bit ok2;
        if (r) begin
            m_mode  = 0;
            m_s1    = 0;
            m_s2    = 0;
            m_win   = 0;
            m_last1 = -1000;
            m_last2 = -1000;
            m_p1q   = 1'b0;
            m_p2q   = 1'b0;
        end else begin
            ok1 = (m_mode == 1) && !ng && p1 && !m_p1q && (m_cyc - m_last1 >= LOCK);
            ok2 = (m_mode == 1) && !ng && p2 && !m_p2q && (m_cyc - m_last2 >= LOCK);
            if (ng) begin
                m_mode = 1;
                m_s1   = 0;
                m_s2   = 0;
                m_win  = 0;
            end else if (m_mode == 1) begin
                if (ok1) begin m_s1++; m_last1 = m_cyc; end
                if (ok2) begin m_s2++; m_last2 = m_cyc; end
                if (m_s1 == WIN || m_s2 == WIN) begin
                    m_win  = ((m_s2 == WIN) ? 2 : 0) + ((m_s1 == WIN) ? 1 : 0);
                    m_mode = 2;
                end
            end
            m_p1q = p1;
            m_p2q = p2;
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        check_val("D",         D,         m_s1 / 10);
        check_val("C",         C,         m_s1 % 10);
        check_val("B",         B,         m_s2 / 10);
        check_val("A",         A,         m_s2 % 10);
        check_val("playing",   playing,   (m_mode == 1) ? 1 : 0);
        check_val("game_over", game_over, (m_mode == 2) ? 1 : 0);
        check_val("winner",    winner,    (m_mode == 2) ? m_win : 0);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model,
    // then compare #1 after the edge.
    task automatic tick(input bit p1, input bit p2, input bit ng, input bit r);
        p1_point = p1;
        p2_point = p2;
        new_game = ng;
        rst      = r;
        @(posedge clk);
        model_step(p1, p2, ng, r);
        #1;
        compare_all();
    endtask

    // One-cycle high pulse followed by low cycles; edges are gap cycles apart.
    task automatic pulse(input bit a, input bit b, input int gap);
        tick(a, b, 1'b0, 1'b0);
        repeat (gap - 1) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        check_val("rst_digits",    {D, C, B, A}, 0);
        check_val("rst_playing",   playing,      0);
        check_val("rst_game_over", game_over,    0);
        check_val("rst_winner",    winner,       0);

        // Points in IDLE are ignored
        repeat (3) pulse(1, 0, 2);
        check_val("idle_digits",  {D, C, B, A}, 0);
        check_val("idle_playing", playing,      0);

        // Held level gives exactly one point
        tick(0, 0, 1, 0);
        repeat (10) tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        check_val("held_one", {D, C}, 8'h01);

        // BCD carry 9 -> 10
        tick(0, 0, 1, 0);
        repeat (10) pulse(1, 0, 6);
        check_val("ten_pts",     {D, C}, 8'h10);
        check_val("ten_playing", playing, 1);

        // Lockout: spacing 2 drops every second edge, spacing 5 keeps all
        tick(0, 0, 1, 0);
        repeat (4) pulse(0, 1, 2);
        check_val("p2_gap2", {B, A}, 8'h02);
        tick(0, 0, 1, 0);
        repeat (4) pulse(0, 1, 5);
        check_val("p2_gap5", {B, A}, 8'h04);

        // P1 wins; OVER freezes scores
        tick(0, 0, 1, 0);
        repeat (15) pulse(1, 0, 6);
        check_val("p1_win_over",    game_over,    1);
        check_val("p1_win_winner",  winner,       1);
        check_val("p1_win_playing", playing,      0);
        check_val("p1_win_digits",  {D, C, B, A}, 16'h1500);
        repeat (3) pulse(1, 1, 6);
        check_val("over_frozen", {D, C, B, A}, 16'h1500);

        // Tie: both reach WIN on the same edge
        tick(0, 0, 1, 0);
        repeat (15) pulse(1, 1, 6);
        check_val("tie_winner", winner,       3);
        check_val("tie_over",   game_over,    1);
        check_val("tie_digits", {D, C, B, A}, 16'h1515);

        // new_game from OVER
        tick(0, 0, 1, 0);
        check_val("restart_digits",  {D, C, B, A}, 0);
        check_val("restart_winner",  winner,       0);
        check_val("restart_playing", playing,      1);

        // Reset with a lockout still pending, then an early edge is accepted
        tick(1, 0, 0, 0);
        check_val("pre_rst_pt", {D, C}, 8'h01);
        tick(0, 0, 0, 1);
        check_val("mid_rst_digits",  {D, C, B, A}, 0);
        check_val("mid_rst_playing", playing,      0);
        tick(0, 0, 1, 0);
        tick(1, 0, 0, 0);
        check_val("post_rst_pt", {D, C}, 8'h01);
        tick(0, 0, 0, 0);

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 799) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
